// File: rtl/reg_file_mux.sv
// Register file with three combinational read ports, write-through bypass and a
// dedicated program-counter register (the last entry) that can self-increment.
module reg_file_mux #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int PC_STEP = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             pc_inc,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] pc,
    output logic             rd_valid
);

    // One extra bit so DEPTH itself is representable when DEPTH == 2^AW.
    localparam logic [AW:0]      DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    PC_IDX  = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_rd_valid;

    logic             w_wr_hit;
    logic [AW-1:0]    w_ra    [3];
    logic [WIDTH-1:0] w_rd    [3];
    logic [2:0]       w_ra_ok;

    assign w_wr_hit = we && ({1'b0, wa} < DEPTH_W);

    assign w_ra[0] = ra0;
    assign w_ra[1] = ra1;
    assign w_ra[2] = ra2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
            logic [WIDTH-1:0] w_data;

            assign w_ra_ok[gi] = ({1'b0, w_ra[gi]} < DEPTH_W);

            // Bypass sees only general writes; a pending pc_inc is not forwarded.
            always_comb begin
                w_data = '0;
                if (w_wr_hit && (wa == w_ra[gi])) begin
                    w_data = wd;
                end else if (w_ra_ok[gi]) begin
                    w_data = r_regs[w_ra[gi]];
                end
            end

            assign w_rd[gi] = w_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_rd_valid <= 1'b0;
        end else begin
            // A general write to the PC takes priority over the increment.
            if (pc_inc && !(w_wr_hit && (wa == PC_IDX))) begin
                r_regs[DEPTH-1] <= r_regs[DEPTH-1] + STEP;
            end
            if (w_wr_hit) begin
                r_regs[wa] <= wd;
            end
            r_rd_valid <= &w_ra_ok;
        end
    end

    assign rd0      = w_rd[0];
    assign rd1      = w_rd[1];
    assign rd2      = w_rd[2];
    assign pc       = r_regs[DEPTH-1];
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_reg_file_mux.sv
// Scoreboard bench for reg_file_mux: the driver pushes the expected outputs of
// each cycle from an array model, a separate monitor compares them mid-cycle.
module tb_reg_file_mux;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 12;
    localparam int AW      = 4;
    localparam int PC_STEP = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             pc_inc;
    logic [AW-1:0]    ra0, ra1, ra2;
    logic [WIDTH-1:0] rd0, rd1, rd2, pc;
    logic             rd_valid;

    reg_file_mux #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .PC_STEP(PC_STEP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .pc_inc  (pc_inc),
        .ra0     (ra0),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd0     (rd0),
        .rd1     (rd1),
        .rd2     (rd2),
        .pc      (pc),
        .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] rd0;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] pc;
        logic             v;
    } exp_t;

    exp_t             sb_q[$];
    int               tests = 0;
    int               fails = 0;
    int               txn   = 0;

    logic [WIDTH-1:0] m_regs [DEPTH];
    logic             m_valid;

    function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] a);
        if (we && int'(wa) < DEPTH && wa == a) return wd;
        if (int'(a) < DEPTH) return m_regs[int'(a)];
        return '0;
    endfunction

    task automatic check(input string name, input int id, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL txn %0d %s: got 0x%08h expected 0x%08h", id, name, act, req);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge, record the expected
    // outputs for this cycle, then advance the model to the next edge.
    task automatic drive(input logic rst_l, input logic w_en, input logic [AW-1:0] w_a,
                         input logic [WIDTH-1:0] w_d, input logic inc,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rst_l; we = w_en; wa = w_a; wd = w_d; pc_inc = inc;
        ra0 = a0; ra1 = a1; ra2 = a2;
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
            m_valid = 1'b0;
        end
        e.id  = txn;
        e.rd0 = model_read(a0);
        e.rd1 = model_read(a1);
        e.rd2 = model_read(a2);
        e.pc  = m_regs[DEPTH-1];
        e.v   = m_valid;
        sb_q.push_back(e);
        txn++;
        if (rst_l) begin
            if (inc && !(w_en && int'(w_a) == DEPTH - 1))
                m_regs[DEPTH-1] = m_regs[DEPTH-1] + WIDTH'(PC_STEP);
            if (w_en && int'(w_a) < DEPTH) m_regs[int'(w_a)] = w_d;
            m_valid = (int'(a0) < DEPTH) && (int'(a1) < DEPTH) && (int'(a2) < DEPTH);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                $display("[TB] txn %0d rst_n=%0b we=%0b wa=%0d pc_inc=%0b ra=%0d/%0d/%0d rd=%08h/%08h/%08h pc=%08h v=%0b",
                         e.id, reset_n, we, wa, pc_inc, ra0, ra1, ra2, rd0, rd1, rd2, pc, rd_valid);
                check("rd0", e.id, rd0, e.rd0);
                check("rd1", e.id, rd1, e.rd1);
                check("rd2", e.id, rd2, e.rd2);
                check("pc", e.id, pc, e.pc);
                check("rd_valid", e.id, {31'b0, rd_valid}, {31'b0, e.v});
            end
        end
    end

    initial begin : stimulus
        logic [AW-1:0] r_wa;
        reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; pc_inc = 1'b0;
        ra0 = '0; ra1 = '0; ra2 = '0;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        m_valid = 1'b0;

        // Reset state and first cycles out of reset
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 4'd3, 4'd3);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 4'd3, 4'd3);
        // Write with same-cycle bypass, then read back
        drive(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd3, 4'd5, 4'd11);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd5, 4'd5, 4'd5);
        // PC increments; the read of the PC shows the pre-increment value
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd11, 4'd5, 4'd0);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd11, 4'd5, 4'd0);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd11, 4'd5, 4'd0);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd11, 4'd11, 4'd11);
        // Wrap-around, and write-beats-increment
        drive(1'b1, 1'b1, 4'd11, 32'hFFFFFFFC, 1'b0, 4'd11, 4'd0, 4'd1);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd11, 4'd0, 4'd1);
        drive(1'b1, 1'b1, 4'd11, 32'h100, 1'b1, 4'd11, 4'd5, 4'd2);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd11, 4'd5, 4'd2);
        // Out-of-range write and read
        drive(1'b1, 1'b1, 4'd13, 32'h12345678, 1'b0, 4'd13, 4'd5, 4'd11);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd13, 4'd15, 4'd12);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd11);
        // Mid-cycle reset after a write; bypass still applies during reset
        drive(1'b1, 1'b1, 4'd2, 32'h55, 1'b0, 4'd2, 4'd5, 4'd11);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 4'd2, 4'd11);
        drive(1'b0, 1'b1, 4'd7, 32'hCAFE0001, 1'b1, 4'd2, 4'd2, 4'd7);
        drive(1'b0, 1'b1, 4'd2, 32'hCAFE0002, 1'b1, 4'd2, 4'd11, 4'd7);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 4'd7, 4'd11);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 4'd7, 4'd11);

        // Randomized traffic, biased toward in-range addresses and PC activity
        for (int n = 0; n < 200; n++) begin
            r_wa = ($urandom_range(0, 4) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
            drive(($urandom_range(0, 40) != 0),
                  ($urandom_range(0, 1) == 1),
                  r_wa,
                  ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : 32'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom_range(0, 13)),
                  ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 11)),
                  AW'($urandom_range(0, 15)));
        end

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
